// File: rtl/softmax_seq_ctrl.sv
// Three-pass softmax sequencer (max search, exp-sum, normalise) for the STAR datapath.
// Optional cycle counter on perf_cycles is enabled by defining SOFTMAX_SEQ_PERF_EN.
module softmax_seq_ctrl #(
  parameter int N  = 256,
  parameter int AW = 9,
  parameter int LW = 16,
  parameter int SW = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          data_req,
  output logic [AW-1:0] data_addr,
  input  logic [7:0]    data,
  output logic          lut_req,
  output logic [7:0]    lut_addr,
  input  logic [LW-1:0] lut_data,
  output logic          div_start,
  output logic [LW-1:0] div_num,
  output logic [SW-1:0] div_den,
  input  logic          div_done,
  input  logic [7:0]    div_q,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [7:0]    out_data,
  output logic          busy,
  output logic          finish,
  output logic [31:0]   perf_cycles,
  output logic [3:0]    dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_MAX, S_EXP, S_EXP_DRAIN, S_NORM_RD,
    S_NORM_LUT, S_NORM_DIV, S_NORM_WAIT, S_ZERO_WR, S_DONE
  } state_t;

  state_t          state_q, state_n;
  logic [AW-1:0]   idx_q, idx_n;
  logic [7:0]      max_q, max_n;
  logic [SW-1:0]   sum_q, sum_n, sum_acc;
  logic            last, start_ok;

  // Strobe semantics: data_req/lut_req/div_start/out_valid are single-cycle
  // qualifiers with no back-pressure; data and lut_data are sampled at the
  // closing edge of the cycle in which the matching request is high, div_done
  // is only honoured in NORM_WAIT. Address/data buses hold when idle.
  logic            data_req_n, lut_req_n, div_start_n, out_valid_n, busy_n, finish_n;
  logic [AW-1:0]   data_addr_n, out_addr_n;
  logic [7:0]      lut_addr_n, out_data_n;
  logic [LW-1:0]   div_num_n;
  logic [SW-1:0]   div_den_n;

  assign last      = (idx_q == AW'(N - 1));
  assign sum_acc   = sum_q + SW'(lut_data);
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign dbg_state = state_q;

  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    max_n       = max_q;
    sum_n       = sum_q;
    data_req_n  = 1'b0;
    data_addr_n = data_addr;
    lut_req_n   = 1'b0;
    lut_addr_n  = lut_addr;
    div_start_n = 1'b0;
    div_num_n   = div_num;
    div_den_n   = div_den;
    out_valid_n = 1'b0;
    out_addr_n  = out_addr;
    out_data_n  = out_data;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n     = S_MAX;
          idx_n       = '0;
          data_req_n  = 1'b1;
          data_addr_n = '0;
        end
      end
      S_MAX: begin
        max_n = (idx_q == '0 || data > max_q) ? data : max_q;
        data_req_n = 1'b1;
        if (last) begin
          state_n     = S_EXP;
          idx_n       = '0;
          sum_n       = '0;
          data_addr_n = '0;
        end else begin
          idx_n       = idx_q + AW'(1);
          data_addr_n = idx_q + AW'(1);
        end
      end
      S_EXP: begin
        lut_req_n  = 1'b1;
        lut_addr_n = max_q - data;
        if (lut_req) sum_n = sum_acc;
        if (last) begin
          state_n = S_EXP_DRAIN;
        end else begin
          idx_n       = idx_q + AW'(1);
          data_req_n  = 1'b1;
          data_addr_n = idx_q + AW'(1);
        end
      end
      S_EXP_DRAIN: begin
        // The last exp value arrives this cycle, so decide on the updated sum.
        sum_n = sum_acc;
        idx_n = '0;
        if (sum_acc != '0) begin
          state_n     = S_NORM_RD;
          data_req_n  = 1'b1;
          data_addr_n = '0;
        end else begin
          state_n     = S_ZERO_WR;
          out_valid_n = 1'b1;
          out_addr_n  = '0;
          out_data_n  = 8'h00;
        end
      end
      S_NORM_RD: begin
        state_n    = S_NORM_LUT;
        lut_req_n  = 1'b1;
        lut_addr_n = max_q - data;
      end
      S_NORM_LUT: begin
        state_n     = S_NORM_DIV;
        div_start_n = 1'b1;
        div_num_n   = lut_data;
        div_den_n   = sum_q;
      end
      S_NORM_DIV: state_n = S_NORM_WAIT;
      S_NORM_WAIT: begin
        if (div_done) begin
          out_valid_n = 1'b1;
          out_addr_n  = idx_q;
          out_data_n  = div_q;
          if (last) begin
            state_n = S_DONE;
          end else begin
            state_n     = S_NORM_RD;
            idx_n       = idx_q + AW'(1);
            data_req_n  = 1'b1;
            data_addr_n = idx_q + AW'(1);
          end
        end
      end
      S_ZERO_WR: begin
        if (last) begin
          state_n = S_DONE;
        end else begin
          idx_n       = idx_q + AW'(1);
          out_valid_n = 1'b1;
          out_addr_n  = idx_q + AW'(1);
          out_data_n  = 8'h00;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n   = !(state_n == S_IDLE || state_n == S_DONE);
    finish_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      max_q     <= '0;
      sum_q     <= '0;
      data_req  <= 1'b0;
      data_addr <= '0;
      lut_req   <= 1'b0;
      lut_addr  <= '0;
      div_start <= 1'b0;
      div_num   <= '0;
      div_den   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      finish    <= 1'b0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      max_q     <= max_n;
      sum_q     <= sum_n;
      data_req  <= data_req_n;
      data_addr <= data_addr_n;
      lut_req   <= lut_req_n;
      lut_addr  <= lut_addr_n;
      div_start <= div_start_n;
      div_num   <= div_num_n;
      div_den   <= div_den_n;
      out_valid <= out_valid_n;
      out_addr  <= out_addr_n;
      out_data  <= out_data_n;
      busy      <= busy_n;
      finish    <= finish_n;
    end
  end

`ifdef SOFTMAX_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        perf_cycles <= '0;
    else if (start_ok) perf_cycles <= '0;
    else if (busy)     perf_cycles <= perf_cycles + 32'd1;
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign perf_cycles     = '0;
`endif

endmodule

// File: doc/softmax_seq_ctrl.md
Name: softmax_seq_ctrl

Overview:
- Three-pass sequencer for the STAR softmax datapath.
- Pass 1 (MAX) fetches all N input bytes over the data_req/data_addr interface and finds the maximum.
- Pass 2 (EXP) refetches each input, looks up exp(max-x) in the external LUT and accumulates the sum.
- Pass 3 (NORM) refetches each input, re-looks-up its exp value, hands numerator and sum to the shared external divider, then writes one result byte per element; finish flags completion.

Parameters:
N, 256, number of input elements (addresses 0..N-1)
AW, 9, data_addr / out_addr width
LW, 16, LUT data width (unsigned)
SW, 24, sum accumulator width (LW + log2 N)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low; 0 forces all state and outputs to reset values
start  in  1  start pulse, sampled only in IDLE or DONE
data_req  out  1  input fetch request
data_addr  out  AW  input fetch address
data  in  8  input byte, valid in same cycle as data_req, captured at that cycle's closing edge
lut_req  out  1  LUT lookup strobe
lut_addr  out  8  LUT index = max - x
lut_data  in  LW  LUT result, valid exactly 1 cycle after lut_req
div_start  out  1  one-cycle divider launch
div_num  out  LW  dividend (exp value)
div_den  out  SW  divisor (sum)
div_done  in  1  divider result valid
div_q  in  8  divider quotient
out_valid  out  1  one-cycle result write strobe
out_addr  out  AW  result index
out_data  out  8  result byte
busy  out  1  high in every state except IDLE/DONE
finish  out  1  high in DONE, held until next accepted start
perf_cycles  out  32  see Optional Feature

Behaviour:
- Reset values: all outputs 0; state IDLE; max, sum, index = 0.
- All outputs are registered.
- IDLE: on start -> MAX, index=0. start is ignored while busy.
- MAX (N cycles):
  - data_req=1, data_addr=index.
  - index 0 loads max=data; later indices update max=max(max,data), unsigned.
  - After index N-1 -> EXP, index=0, sum=0.
- EXP (N cycles):
  - data_req=1 each cycle.
  - Next cycle: lut_req=1, lut_addr=max-data. This never underflows.
  - One cycle later: sum+=lut_data, zero-extended, no saturation; SW guarantees no overflow.
  - After last fetch -> EXP_DRAIN.
- EXP_DRAIN: waits 1 cycle to absorb the final lut_data. Then:
  - sum!=0 -> NORM_RD, index=0.
  - sum==0 -> ZERO_WR.
- NORM_RD -> NORM_LUT -> NORM_DIV -> NORM_WAIT, per element:
  - NORM_RD: data_req, data_addr=index.
  - NORM_LUT: lut_req, lut_addr=max-data.
  - NORM_DIV: div_start=1, div_num=lut_data, div_den=sum.
  - NORM_WAIT: holds until div_done=1, then registers out_valid=1, out_addr=index, out_data=div_q.
  - Next: index+1 -> NORM_RD, or DONE after index N-1.
  - out_valid is therefore high during the following state's first cycle.
- ZERO_WR: one cycle per index, out_valid=1, out_data=0; div_start never pulses. After N-1 -> DONE.
- DONE: finish=1, busy=0. On start: finish drops next cycle, sequence restarts as from IDLE.
- div_done outside NORM_WAIT is ignored.
- data/lut_data outside their expected cycles are ignored (data may be Z).
- data_req and lut_req are never high simultaneously with stale addresses; address ports hold their last value when the request is low.
- Reset asserted mid-operation: immediate return to IDLE, outputs 0. No partial result write is completed.
- Latency, divider with div_done 1 cycle after div_start (D=1):
  - finish rises 6N+1 cycles after the edge that samples start: N MAX + N EXP + 1 drain + 4N NORM.
  - Each extra divider cycle adds N.

Optional Feature:
- Macro SOFTMAX_SEQ_PERF_EN.
- Defined:
  - perf_cycles clears on accepted start.
  - It increments every busy cycle and freezes in DONE.
- Undefined: perf_cycles tied to 0, no counter flops.

Test Plan:
1. Bench divider returns (num<<8)/den with D=1.
   - Uniform: all inputs 5, LUT constant 0x0100.
   - Required: sum=65536, all 256 out_data=1, out_addr 0..255 in order, finish at cycle 1537.
2. Ramp: input[i]=i.
   - Required: max=255.
   - In EXP, lut_addr for address i equals 255-i.
   - lut_req is seen exactly 256 times per pass.
3. Zero sum: LUT all 0.
   - Required: div_start never asserts.
   - 256 out_valid pulses with out_data=0.
   - finish at 2N+1+N cycles.
4. Reset mid-run: reset low during NORM_WAIT of index 37.
   - Required: all outputs 0 within the reset cycle.
   - A new start yields a complete, correct run from index 0.
5. start pulsed during MAX and NORM: ignored, results unchanged. start in DONE: finish drops next cycle, second identical run.
6. Stretched divider: div_done returns after 5 cycles and div_done is pulsed spuriously in NORM_RD.
   - Required: the spurious pulse is ignored.
   - finish at 10N+1.
   - With SOFTMAX_SEQ_PERF_EN, perf_cycles=10N+1.
